// File: rtl/div3_rr_scheduler_if.sv
// Request/result bundle for the shared mod-3 engine: per-requester valid/ready/data
// in, one valid/ready result port out.
interface div3_rr_scheduler_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [IDW-1:0]        res_id;
    logic [1:0]            res_rem;
    logic                  res_div3;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_id, res_rem, res_div3
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_id, res_rem, res_div3
    );
endinterface

// File: rtl/div3_rr_scheduler.sv
// Round-robin arbiter in front of a single bit-serial mod-3 engine; the granted word
// is shifted MSB-first and its remainder is returned with the owner's ID.
module div3_rr_scheduler #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                resetn,
    div3_rr_scheduler_if.slave  bus,
    output logic                busy
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [1:0]       rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             valid_q, valid_d;
    logic [1:0]       res_rem_q, res_rem_d;
    logic             div3_q, div3_d;

    logic             found;
    logic [IDW-1:0]   gnt;
    logic [1:0]       rem_nxt;

    // First valid requester after the last grant, wrapping modulo NREQ.
    always_comb begin : arb
        int unsigned idx;
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_q) + k) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gnt   = IDW'(idx);
            end
        end
    end

    // rem' = (2*rem + bit) mod 3 as a 2-bit state transition.
    always_comb begin
        rem_nxt = 2'd0;
        case ({rem_q, shreg_q[WIDTH-1]})
            3'b000:  rem_nxt = 2'd0;
            3'b001:  rem_nxt = 2'd1;
            3'b010:  rem_nxt = 2'd2;
            3'b011:  rem_nxt = 2'd0;
            3'b100:  rem_nxt = 2'd1;
            3'b101:  rem_nxt = 2'd2;
            default: rem_nxt = 2'd0;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == IDLE && found) bus.req_ready[gnt] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        id_d      = id_q;
        valid_d   = valid_q;
        res_rem_d = res_rem_q;
        div3_d    = div3_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    shreg_d = bus.req_data[32'(gnt)*WIDTH +: WIDTH];
                    rem_d   = 2'd0;
                    cnt_d   = CW'(WIDTH);
                    id_d    = gnt;
                    last_d  = gnt;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                rem_d   = rem_nxt;
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    res_rem_d = rem_nxt;
                    div3_d    = (rem_nxt == 2'd0);
                    valid_d   = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            rem_q     <= 2'd0;
            cnt_q     <= '0;
            last_q    <= IDW'(NREQ - 1);
            id_q      <= '0;
            valid_q   <= 1'b0;
            res_rem_q <= 2'd0;
            div3_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            res_rem_q <= res_rem_d;
            div3_q    <= div3_d;
        end
    end

    assign bus.res_valid = valid_q;
    assign bus.res_id    = id_q;
    assign bus.res_rem   = res_rem_q;
    assign bus.res_div3  = div3_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_div3_rr_scheduler.sv
// Directed and randomised checks of div3_rr_scheduler with NREQ=4, WIDTH=8.
module tb_div3_rr_scheduler;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic resetn;
    logic busy;

    int n_cmp = 0;
    int n_err = 0;
    int model_last;

    div3_rr_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    div3_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] d);
        bus.req_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        resetn     = 1'b1;
        model_last = NREQ - 1;
    endtask

    // Called right after the handshake edge; result must appear after WIDTH edges.
    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (bus.res_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, WIDTH);
    endtask

    task automatic consume(input string tag);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk({tag, "_valid_cleared"}, bus.res_valid, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    // Inputs already driven: check grant, run the job, check the result, consume it.
    task automatic job(input string tag, input logic [3:0] exp_rdy, input int exp_id,
                       input int exp_rem);
        #1;
        chk({tag, "_ready"}, bus.req_ready, exp_rdy);
        tick();
        bus.req_valid[exp_id] = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        wait_result(tag);
        chk({tag, "_id"}, bus.res_id, exp_id);
        chk({tag, "_rem"}, bus.res_rem, exp_rem);
        chk({tag, "_div3"}, bus.res_div3, (exp_rem == 0) ? 1 : 0);
        consume(tag);
    endtask

    initial begin
        logic [3:0] pending;
        logic [7:0] pdata [NREQ];
        int         waits [NREQ];
        int         g, r, idx;
        logic       fair;

        // Reset state
        do_reset();
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_id", bus.res_id, 0);
        chk("rst_rem", bus.res_rem, 0);
        chk("rst_div3", bus.res_div3, 0);
        chk("rst_ready", bus.req_ready, 0);

        // First job
        bus.req_valid = 4'b0001;
        set_data(0, 8'h03);
        job("t1", 4'b0001, 0, 0);

        // Single requester words
        bus.req_valid = 4'b0010; set_data(1, 8'hFF); job("t2_ff", 4'b0010, 1, 0);
        bus.req_valid = 4'b0010; set_data(1, 8'h64); job("t2_64", 4'b0010, 1, 1);
        bus.req_valid = 4'b0010; set_data(1, 8'h05); job("t2_05", 4'b0010, 1, 2);
        bus.req_valid = 4'b0010; set_data(1, 8'h00); job("t2_00", 4'b0010, 1, 0);

        // All four at once from a fresh pointer, then 2 and 0
        do_reset();
        set_data(0, 8'd3); set_data(1, 8'd4); set_data(2, 8'd5); set_data(3, 8'd6);
        bus.req_valid = 4'b1111;
        job("t3_g0", 4'b0001, 0, 0);
        job("t3_g1", 4'b0010, 1, 1);
        job("t3_g2", 4'b0100, 2, 2);
        job("t3_g3", 4'b1000, 3, 0);
        set_data(0, 8'd9); set_data(2, 8'd7);
        bus.req_valid = 4'b0101;
        job("t3_again0", 4'b0001, 0, 0);
        job("t3_again2", 4'b0100, 2, 1);

        // Backpressure in DONE with everyone requesting
        for (int i = 0; i < 4; i++) set_data(i, 8'(10 + i));
        bus.req_valid = 4'b1111;
        #1;
        chk("t4_ready", bus.req_ready, 4'b1000);
        tick();
        wait_result("t4");
        for (int c = 0; c < 5; c++) begin
            chk("t4_hold_valid", bus.res_valid, 1);
            chk("t4_hold_id", bus.res_id, 3);
            chk("t4_hold_rem", bus.res_rem, 1);
            chk("t4_hold_ready", bus.req_ready, 0);
            chk("t4_hold_busy", busy, 1);
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("t4_rel_valid", bus.res_valid, 0);
        chk("t4_rel_busy", busy, 0);
        chk("t4_rel_ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        wait_result("t4_next");
        chk("t4_next_id", bus.res_id, 0);
        chk("t4_next_rem", bus.res_rem, 1);
        consume("t4_next");

        // Reset on the third shift edge
        bus.req_valid = 4'b0010;
        set_data(1, 8'h55);
        #1;
        chk("t5_ready", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        resetn = 1'b0;
        tick();
        chk("t5_valid", bus.res_valid, 0);
        chk("t5_busy", busy, 0);
        resetn = 1'b1;
        set_data(0, 8'h0C); set_data(3, 8'h0E);
        bus.req_valid = 4'b1001;
        job("t5_g0", 4'b0001, 0, 0);
        job("t5_g3", 4'b1000, 3, 2);

        // Randomised jobs against a round-robin model
        do_reset();
        pending = '0;
        for (int i = 0; i < NREQ; i++) begin
            waits[i] = 0;
            pdata[i] = '0;
        end
        for (int j = 0; j < 200; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    pending[i] = 1'b1;
                    pdata[i]   = 8'($urandom);
                    waits[i]   = 0;
                end
            end
            if (pending == 4'b0000) begin
                r          = int'($urandom_range(0, NREQ - 1));
                pending[r] = 1'b1;
                pdata[r]   = 8'($urandom);
                waits[r]   = 0;
            end
            bus.req_valid = pending;
            for (int i = 0; i < NREQ; i++) set_data(i, pdata[i]);
            g = -1;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (model_last + k) % NREQ;
                if (g < 0 && pending[idx]) g = idx;
            end
            #1;
            chk("rnd_ready", bus.req_ready, 4'b0001 << g);
            tick();
            pending[g]       = 1'b0;
            bus.req_valid[g] = 1'b0;
            model_last       = g;
            fair             = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (pending[i]) begin
                    waits[i]++;
                    if (waits[i] > NREQ) fair = 1'b0;
                end
            end
            chk("rnd_fair", fair, 1);
            wait_result("rnd");
            chk("rnd_id", bus.res_id, g);
            chk("rnd_rem", bus.res_rem, pdata[g] % 3);
            chk("rnd_div3", bus.res_div3, (pdata[g] % 3 == 0) ? 1 : 0);
            repeat ($urandom_range(0, 3)) begin
                chk("rnd_stall_valid", bus.res_valid, 1);
                tick();
            end
            consume("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
